show_display: RTL and testbench
===============================

SHOW_DISPLAY -- requirements
Module: show_display

Interface
REQ-001 Parameter REFRESH_DIV, default 16, clock cycles each digit stays enabled (legal range 2..65535).
REQ-002 Parameter FLASH_CYCLES, default 1024, decimal-point flash length after a capture (legal range 1..65535; used only with SHOW_DISPLAY_FLASH_EN).
REQ-003 clk  input  1  single clock; all state on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Show  input  2  display command from the processor core: 00 idle, 01 capture slot 0, 10 capture slot 1, 11 clear both slots.
REQ-006 ShowData  input  8  value sampled on a capture command.
REQ-007 seg  output  7  segments a..g (bit 0 = a), active-low, registered.
REQ-008 an  output  4  digit enables, active-low, one-hot-low, registered.
REQ-009 dp  output  1  decimal point, active-low, registered.
REQ-010 cap_cnt  output  8  count of capture commands (01 or 10), wraps 255->0.

Function
REQ-011 Show is sampled every clk edge; each non-idle cycle is one command; no handshake, no back-pressure.
REQ-012 Show=01: slot0 <= ShowData on that edge; Show=10: slot1 <= ShowData; Show=11: slot0 <= 0 and slot1 <= 0, ShowData ignored.
REQ-013 cap_cnt increments by 1 on each edge with Show=01 or 10; it is unchanged on 00 and 11.
REQ-014 Refresh counter counts 0..REFRESH_DIV-1 and wraps; digit index (2 bits) advances 0->1->2->3->0 on the edge where the counter equals REFRESH_DIV-1.
REQ-015 Digit mapping: 0 = slot0[3:0], 1 = slot0[7:4], 2 = slot1[3:0], 3 = slot1[7:4]; an[i] = 0 only for the current digit i.
REQ-016 seg, an and dp are registered from the current digit index and slot contents, giving one cycle of latency.
REQ-017 A capture is visible on seg no later than 1 cycle after its edge if the digit is selected, and otherwise within 4*REFRESH_DIV+1 cycles.
REQ-018 seg encodes hexadecimal 0..F with standard 7-segment glyphs (b and d in lowercase).
REQ-019 If a capture and a digit advance occur on the same edge, the newly selected digit shows the new slot value one cycle later.
REQ-020 Back-to-back commands on consecutive cycles are all honoured; the last write to a slot wins.
REQ-021 Without the flash feature, dp = 1 (off) at all times.

Reset
REQ-022 On reset low, immediately and regardless of clk: slot0 = slot1 = 0, cap_cnt = 0, refresh counter = 0, digit index = 0, seg = 7'h7F, an = 4'hF, dp = 1, and flash timers = 0.
REQ-023 After reset release, the first registered output update shows digit 0 (an = 4'hE, seg = glyph 0 = 7'h40).
REQ-024 Reset during scanning or during a flash aborts it; no partial state survives.

Configuration
REQ-025 Macro SHOW_DISPLAY_FLASH_EN: when defined, each capture loads a per-slot down-counter with FLASH_CYCLES.
REQ-026 With SHOW_DISPLAY_FLASH_EN, dp = 0 while the current digit belongs to a slot whose counter is nonzero, and the counter decrements once per cycle to 0.
REQ-027 With SHOW_DISPLAY_FLASH_EN, a re-capture reloads the counter and Show=11 clears both counters.
REQ-028 Without SHOW_DISPLAY_FLASH_EN, no flash counters are built and REQ-021 holds.

Structure
REQ-029 Package show_pkg holds the show_op_e enum (IDLE, CAP0, CAP1, CLEAR) and the 16-entry hex-to-segment constant table.
REQ-030 One sub-module, hex7seg: a combinational 4-bit to 7-bit active-low decoder with a single instance.
REQ-031 Counter widths are derived with $clog2 from the parameters.

Verification (REFRESH_DIV=4, FLASH_CYCLES=8)
REQ-032 Reset released, Show=00 -> an cycles E,D,B,7 every 4 cycles and seg = 7'h40 on all digits.
REQ-033 Show=01 with ShowData=8'hA5 for 1 cycle -> digit0 seg = glyph 5 (7'h12), digit1 seg = glyph A (7'h08), cap_cnt = 1.
REQ-034 Show=10 with 8'h3C, then Show=11 on the next cycle -> all digits return to glyph 0 and cap_cnt = 1.
REQ-035 256 consecutive Show=01 cycles -> cap_cnt wraps to 0, and slot0 holds the last ShowData.
REQ-036 reset asserted mid-scan with an=B -> an = F and seg = 7F asynchronously, before the next clk edge.
REQ-037 With SHOW_DISPLAY_FLASH_EN, Show=10 -> dp = 0 on digits 2/3 for 8 cycles and then 1; without the macro, dp stays 1.

Source files
------------

// File: rtl/show_pkg.sv
// Shared types and the hex glyph table for the show_display block.
// Glyphs are active-low, bit 0 = segment a; b and d are lowercase.
package show_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CAP0  = 2'b01,
    CAP1  = 2'b10,
    CLEAR = 2'b11
  } show_op_e;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/show_display_hex7seg.sv
// Combinational nibble-to-glyph decoder, active-low segments; zero latency, no flow control.
module hex7seg
  import show_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_GLYPH[i_hex];

endmodule

// File: rtl/show_display.sv
// Two-slot 4-digit multiplexed hex display; outputs registered (1 cycle), no back-pressure on Show.
// Optional capture flash on the decimal point under `define SHOW_DISPLAY_FLASH_EN.
module show_display
  import show_pkg::*;
#(
  parameter int REFRESH_DIV  = 16,
  parameter int FLASH_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Show,
  input  logic [7:0] ShowData,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [7:0] cap_cnt
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);

  show_op_e    w_op;
  logic [7:0]  r_slot0;
  logic [7:0]  r_slot1;
  logic [7:0]  r_cap_cnt;
  logic [RW-1:0] r_refresh;
  logic [1:0]  r_digit;
  logic [6:0]  r_seg;
  logic [3:0]  r_an;
  logic        r_dp;
  logic [3:0]  w_nibble;
  logic [6:0]  w_glyph;
  logic        w_dp_next;

  assign w_op = show_op_e'(Show);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot0   <= '0;
      r_slot1   <= '0;
      r_cap_cnt <= '0;
    end else begin
      unique case (w_op)
        CAP0: begin
          r_slot0   <= ShowData;
          r_cap_cnt <= r_cap_cnt + 8'd1;
        end
        CAP1: begin
          r_slot1   <= ShowData;
          r_cap_cnt <= r_cap_cnt + 8'd1;
        end
        CLEAR: begin
          r_slot0 <= '0;
          r_slot1 <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refresh <= '0;
      r_digit   <= '0;
    end else if (r_refresh == R_LAST) begin
      r_refresh <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  always_comb begin
    w_nibble = r_slot0[3:0];
    case (r_digit)
      2'd0: w_nibble = r_slot0[3:0];
      2'd1: w_nibble = r_slot0[7:4];
      2'd2: w_nibble = r_slot1[3:0];
      2'd3: w_nibble = r_slot1[7:4];
      default: w_nibble = r_slot0[3:0];
    endcase
  end

  hex7seg u_hex7seg (
    .i_hex (w_nibble),
    .o_seg (w_glyph)
  );

`ifdef SHOW_DISPLAY_FLASH_EN
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  logic [FW-1:0] r_flash0;
  logic [FW-1:0] r_flash1;

  // A capture reloads its slot's timer; otherwise timers drain to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flash0 <= '0;
      r_flash1 <= '0;
    end else begin
      r_flash0 <= (r_flash0 != '0) ? r_flash0 - FW'(1) : '0;
      r_flash1 <= (r_flash1 != '0) ? r_flash1 - FW'(1) : '0;
      unique case (w_op)
        CAP0:  r_flash0 <= FW'(FLASH_CYCLES);
        CAP1:  r_flash1 <= FW'(FLASH_CYCLES);
        CLEAR: begin
          r_flash0 <= '0;
          r_flash1 <= '0;
        end
        default: ;
      endcase
    end
  end

  assign w_dp_next = r_digit[1] ? (r_flash1 == '0) : (r_flash0 == '0);
`else
  assign w_dp_next = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg <= 7'h7F;
      r_an  <= 4'hF;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_glyph;
      r_an  <= ~(4'b0001 << r_digit);
      r_dp  <= w_dp_next;
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign dp      = r_dp;
  assign cap_cnt = r_cap_cnt;

endmodule

// File: tb/tb_show_display.sv
// Directed bench for show_display with a scan scoreboard (REFRESH_DIV=4, FLASH_CYCLES=8).
module tb_show_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Show;
  logic [7:0] ShowData;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic [7:0] cap_cnt;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t       sb_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] mon_prev_an = 4'hF;

  show_display #(.REFRESH_DIV(4), .FLASH_CYCLES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .Show     (Show),
    .ShowData (ShowData),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .cap_cnt  (cap_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Each new digit presentation consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && sb_q.size() > 0 && an !== mon_prev_an) begin
      e = sb_q.pop_front();
      chk("scan_an", an, e.an);
      chk("scan_seg", seg, e.seg);
      chk("scan_dp", dp, e.dp);
    end
    mon_prev_an = an;
  end

  task automatic send(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    Show     = op;
    ShowData = data;
  endtask

  task automatic expect_scan(input logic [6:0] g0, input logic [6:0] g1,
                             input logic [6:0] g2, input logic [6:0] g3);
    int budget;
    repeat (20) @(negedge clk);
    budget = 0;
    while (an !== 4'h7 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (an !== 4'h7) begin
      chk("scan_sync", an, 4'h7);
      return;
    end
    @(posedge clk);
    sb_q.push_back('{an: 4'hE, seg: g0, dp: 1'b1});
    sb_q.push_back('{an: 4'hD, seg: g1, dp: 1'b1});
    sb_q.push_back('{an: 4'hB, seg: g2, dp: 1'b1});
    sb_q.push_back('{an: 4'h7, seg: g3, dp: 1'b1});
    budget = 0;
    while (sb_q.size() > 0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() > 0) begin
      chk("scan_drain", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_an", an, 4'hE);
    chk("post_reset_seg", seg, 7'h40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int         budget;
    logic [3:0] prev;

    reset = 1'b0;
    Show = 2'b00;
    ShowData = 8'h00;
    #12;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_dp", dp, 1'b1);
    chk("rst_cap_cnt", cap_cnt, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("first_an", an, 4'hE);
    chk("first_seg", seg, 7'h40);

    expect_scan(7'h40, 7'h40, 7'h40, 7'h40);

    send(2'b01, 8'hA5);
    send(2'b00, 8'h00);
    chk("cap_a5", cap_cnt, 8'd1);
    expect_scan(7'h12, 7'h08, 7'h40, 7'h40);

    send(2'b10, 8'h3C);
    send(2'b00, 8'h00);
    chk("cap_3c", cap_cnt, 8'd2);
    expect_scan(7'h12, 7'h08, 7'h46, 7'h30);

    pulse_reset();
    send(2'b10, 8'h3C);
    send(2'b11, 8'h77);
    send(2'b00, 8'h00);
    chk("cap_clear", cap_cnt, 8'd1);
    expect_scan(7'h40, 7'h40, 7'h40, 7'h40);

    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b10, 8'h9E);
    send(2'b00, 8'h00);
    chk("cap_b2b", cap_cnt, 8'd4);
    expect_scan(7'h24, 7'h24, 7'h06, 7'h10);

    pulse_reset();
    for (int i = 0; i < 256; i++) send(2'b01, i[7:0]);
    send(2'b00, 8'h00);
    chk("cap_wrap", cap_cnt, 8'd0);
    expect_scan(7'h0E, 7'h0E, 7'h40, 7'h40);

    // Land the slot-1 capture on the edge where digit 2 becomes current.
    budget = 0;
    prev = an;
    @(negedge clk);
    while (!(an === 4'hD && prev !== 4'hD) && budget < 40) begin
      prev = an;
      @(negedge clk);
      budget++;
    end
    if (an !== 4'hD) begin
      chk("flash_sync", an, 4'hD);
    end else begin
      @(negedge clk);
      @(negedge clk);
      Show = 2'b10;
      ShowData = 8'h5A;
      @(negedge clk);
      Show = 2'b00;
      chk("flash_pre_dp", dp, 1'b1);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk("flash_an", an, (k < 4) ? 4'hB : 4'h7);
`ifdef SHOW_DISPLAY_FLASH_EN
        chk("flash_dp", dp, 1'b0);
`else
        chk("flash_dp", dp, 1'b1);
`endif
      end
      @(negedge clk);
      chk("flash_post_dp", dp, 1'b1);
    end

    budget = 0;
    while (an !== 4'hB && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    chk("async_sync", an, 4'hB);
    chk("async_pre_cap", cap_cnt, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_dp", dp, 1'b1);
    chk("async_cap", cap_cnt, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("async_rel_an", an, 4'hE);
    chk("async_rel_seg", seg, 7'h40);
    chk("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
